// File: rtl/exc_sequencer_if.sv
// Signal bundle between the exception sequencer, the pipeline and CP0.
// Handshake: exc_req, eret and the irq levels are sampled only while the
// sequencer is idle; the pipeline holds them until it sees exc_enter or
// pc_redirect. exc_enter and pc_redirect are one-cycle strobes with no
// back-pressure; their payload fields are valid only while the strobe is high.
interface exc_sequencer_if;
   logic [4:0]  irq_in;
   logic [7:0]  sr_im;
   logic        sr_ie;
   logic [31:0] epc;
   logic        cp0_we;
   logic        inst_boundary;
   logic [31:0] pc_boundary;
   logic        exc_req;
   logic [4:0]  exc_code_in;
   logic [31:0] exc_pc;
   logic        eret;
   logic        exc_enter;
   logic [4:0]  exc_code;
   logic [4:0]  hw_int;
   logic [31:0] cp0_din;
   logic        stall;
   logic        pc_redirect;
   logic [31:0] redirect_pc;
   logic        in_handler;
   logic [1:0]  state_dbg;

   modport slave (
      input  irq_in, sr_im, sr_ie, epc, cp0_we, inst_boundary, pc_boundary,
             exc_req, exc_code_in, exc_pc, eret,
      output exc_enter, exc_code, hw_int, cp0_din, stall, pc_redirect,
             redirect_pc, in_handler, state_dbg
   );

   modport master (
      output irq_in, sr_im, sr_ie, epc, cp0_we, inst_boundary, pc_boundary,
             exc_req, exc_code_in, exc_pc, eret,
      input  exc_enter, exc_code, hw_int, cp0_din, stall, pc_redirect,
             redirect_pc, in_handler, state_dbg
   );
endinterface

// File: rtl/exc_sequencer.sv
// Exception/interrupt sequencer: synchronises IRQs, arbitrates them against
// pipeline exceptions, pulses CP0 exception entry and redirects fetch.
module exc_sequencer #(
   parameter logic [31:0] HANDLER_VEC = 32'h0000_4180,
   parameter int          SYNC_STAGES = 2
) (
   input  logic           clk,
   input  logic           reset,
   exc_sequencer_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ENTER    = 2'd1,
      REDIRECT = 2'd2,
      RETURN   = 2'd3
   } state_t;

   state_t      state, state_next;
   logic [4:0]  sync_q [SYNC_STAGES];
   logic [4:0]  irq_sync, pend;
   logic        take_irq;
   logic        accept_exc, accept_irq, accept_ret;
   logic [4:0]  code_q, hw_q;
   logic [31:0] epc_q, ret_q;
   logic        in_handler_q;
   logic        enter;
   logic [4:0]  code_out, hw_out;
   logic [31:0] din_out, rpc_out;
   logic        stall_out, redirect_out;
   logic        sr_im_unused;

   assign sr_im_unused = ^{bus.sr_im[7], bus.sr_im[0]};

   assign irq_sync = sync_q[SYNC_STAGES-1];
   assign pend     = irq_sync & bus.sr_im[6:2];
   assign take_irq = (|pend) & bus.sr_ie & ~bus.sr_im[1] & bus.inst_boundary;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= bus.irq_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         code_q       <= '0;
         hw_q         <= '0;
         epc_q        <= '0;
         ret_q        <= '0;
         in_handler_q <= 1'b0;
      end else begin
         state <= state_next;
         if (accept_exc) begin
            code_q <= bus.exc_code_in;
            epc_q  <= bus.exc_pc;
            hw_q   <= pend;
         end else if (accept_irq) begin
            code_q <= '0;
            epc_q  <= bus.pc_boundary;
            hw_q   <= pend;
         end
         if (accept_ret) begin
            ret_q        <= bus.epc;
            in_handler_q <= 1'b0;
         end
         if (enter) in_handler_q <= 1'b1;
      end
   end

   always_comb begin
      state_next   = state;
      accept_exc   = 1'b0;
      accept_irq   = 1'b0;
      accept_ret   = 1'b0;
      enter        = 1'b0;
      code_out     = '0;
      hw_out       = '0;
      din_out      = '0;
      stall_out    = 1'b0;
      redirect_out = 1'b0;
      rpc_out      = '0;
      case (state)
         IDLE: begin
            if (bus.exc_req) begin
               accept_exc = 1'b1;
               state_next = ENTER;
            end else if (take_irq) begin
               accept_irq = 1'b1;
               state_next = ENTER;
            end else if (bus.eret) begin
               accept_ret = 1'b1;
               state_next = RETURN;
            end
         end
         ENTER: begin
            stall_out = 1'b1;
            // Entry is withheld while CP0 takes an mtc0 write, and never fires under reset.
            if (!bus.cp0_we && !reset) begin
               enter      = 1'b1;
               code_out   = code_q;
               hw_out     = hw_q;
               din_out    = epc_q;
               state_next = REDIRECT;
            end
         end
         REDIRECT: begin
            stall_out    = 1'b1;
            redirect_out = 1'b1;
            rpc_out      = HANDLER_VEC;
            state_next   = IDLE;
         end
         RETURN: begin
            redirect_out = 1'b1;
            rpc_out      = ret_q;
            state_next   = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.exc_enter   = enter;
   assign bus.exc_code    = code_out;
   assign bus.hw_int      = hw_out;
   assign bus.cp0_din     = din_out;
   assign bus.stall       = stall_out;
   assign bus.pc_redirect = redirect_out;
   assign bus.redirect_pc = rpc_out;
   assign bus.in_handler  = in_handler_q;
   assign bus.state_dbg   = state;
endmodule

// File: tb/tb_exc_sequencer.sv
// Bench for exc_sequencer: table-driven sync/eret vectors, directed corner
// sequences, and a randomized run against a frame-queue reference model.
module tb_exc_sequencer;
   localparam logic [31:0] HVEC = 32'h0000_4180;
   localparam int          SS   = 2;

   // clock / reset
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   exc_sequencer_if bus ();
   exc_sequencer #(.HANDLER_VEC(HVEC), .SYNC_STAGES(SS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [79:0] pack_out(input logic en, input logic [4:0] code,
                                            input logic [4:0] hw, input logic [31:0] din,
                                            input logic st, input logic pr,
                                            input logic [31:0] rpc, input logic ih);
      return {2'b00, en, code, hw, din, st, pr, rpc, ih};
   endfunction

   function automatic logic [79:0] actual_out();
      return pack_out(bus.exc_enter, bus.exc_code, bus.hw_int, bus.cp0_din,
                      bus.stall, bus.pc_redirect, bus.redirect_pc, bus.in_handler);
   endfunction

   // reference model: a queue of upcoming busy-cycle frames
   typedef enum {F_ENTER, F_VECTOR, F_RETURN} kind_t;
   typedef struct {
      kind_t       kind;
      logic [4:0]  code;
      logic [4:0]  hw;
      logic [31:0] pc;
   } frame_t;

   frame_t     fq[$];
   logic [4:0] irq_hist[$];
   logic       m_in_handler = 1'b0;
   bit         mon_en = 1'b0;

   function automatic logic [79:0] model_expect();
      if (fq.size() == 0) return pack_out(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, m_in_handler);
      case (fq[0].kind)
         F_ENTER:
            if (bus.cp0_we || reset) return pack_out(1'b0, '0, '0, '0, 1'b1, 1'b0, '0, m_in_handler);
            else return pack_out(1'b1, fq[0].code, fq[0].hw, fq[0].pc, 1'b1, 1'b0, '0, m_in_handler);
         F_VECTOR: return pack_out(1'b0, '0, '0, '0, 1'b1, 1'b1, HVEC, m_in_handler);
         default:  return pack_out(1'b0, '0, '0, '0, 1'b0, 1'b1, fq[0].pc, m_in_handler);
      endcase
   endfunction

   task automatic model_edge();
      logic [4:0] seen, pend;
      seen = (irq_hist.size() >= SS) ? irq_hist[irq_hist.size()-SS] : 5'd0;
      pend = seen & bus.sr_im[6:2];
      if (reset) begin
         fq.delete();
         irq_hist.delete();
         m_in_handler = 1'b0;
         return;
      end
      if (fq.size() != 0) begin
         if (fq[0].kind != F_ENTER) void'(fq.pop_front());
         else if (!bus.cp0_we) begin
            m_in_handler = 1'b1;
            void'(fq.pop_front());
         end
      end else if (bus.exc_req) begin
         fq.push_back(frame_t'{F_ENTER, bus.exc_code_in, pend, bus.exc_pc});
         fq.push_back(frame_t'{F_VECTOR, 5'd0, 5'd0, HVEC});
      end else if ((|pend) && bus.sr_ie && !bus.sr_im[1] && bus.inst_boundary) begin
         fq.push_back(frame_t'{F_ENTER, 5'd0, pend, bus.pc_boundary});
         fq.push_back(frame_t'{F_VECTOR, 5'd0, 5'd0, HVEC});
      end else if (bus.eret) begin
         m_in_handler = 1'b0;
         fq.push_back(frame_t'{F_RETURN, 5'd0, 5'd0, bus.epc});
      end
      irq_hist.push_back(bus.irq_in);
      if (irq_hist.size() > 8) void'(irq_hist.pop_front());
   endtask

   // scoreboard monitor: model advances on each edge, outputs compared mid-cycle
   initial begin
      forever begin
         @(posedge clk);
         model_edge();
         #4;
         if (mon_en) check("model_cycle", actual_out(), model_expect());
      end
   end

   // driver tasks
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.irq_in = '0;        bus.sr_im = '0;        bus.sr_ie = 1'b0;
      bus.epc = '0;           bus.cp0_we = 1'b0;     bus.inst_boundary = 1'b0;
      bus.pc_boundary = '0;   bus.exc_req = 1'b0;    bus.exc_code_in = '0;
      bus.exc_pc = '0;        bus.eret = 1'b0;
   endtask

   typedef struct {
      logic        req;
      logic [4:0]  code;
      logic [31:0] pc;
      logic        eret;
      logic [31:0] epc;
      logic        exp_enter;
      logic [4:0]  exp_code;
      logic [31:0] exp_din;
      int          redir_cyc;
      logic [31:0] exp_rpc;
      logic        exp_ih;
   } vec_t;

   vec_t vecs[6];
   int   lat, cnt, held;
   bit   got;

   initial begin
      vecs[0] = vec_t'{1'b1, 5'd12, 32'h0000_3000, 1'b0, 32'h0, 1'b1, 5'd12, 32'h0000_3000, 2, HVEC, 1'b1};
      vecs[1] = vec_t'{1'b1, 5'd4,  32'h0000_1234, 1'b0, 32'h0, 1'b1, 5'd4,  32'h0000_1234, 2, HVEC, 1'b1};
      vecs[2] = vec_t'{1'b0, 5'd0,  32'h0,         1'b1, 32'h0000_3014, 1'b0, 5'd0, 32'h0, 1, 32'h0000_3014, 1'b0};
      vecs[3] = vec_t'{1'b1, 5'd8,  32'h0000_2000, 1'b1, 32'h0000_5000, 1'b1, 5'd8, 32'h0000_2000, 2, HVEC, 1'b1};
      vecs[4] = vec_t'{1'b1, 5'd31, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 5'd31, 32'hFFFF_FFFC, 2, HVEC, 1'b1};
      vecs[5] = vec_t'{1'b0, 5'd0,  32'h0,         1'b1, 32'h0000_0100, 1'b0, 5'd0, 32'h0, 1, 32'h0000_0100, 1'b0};

      idle_inputs();
      repeat (3) cyc();
      check("reset_outputs", actual_out(), pack_out(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0));
      reset = 1'b0;
      mon_en = 1'b1;
      repeat (2) cyc();

      // table: sync exceptions and erets from idle
      for (int i = 0; i < 6; i++) begin
         bus.exc_req = vecs[i].req;  bus.exc_code_in = vecs[i].code;  bus.exc_pc = vecs[i].pc;
         bus.eret = vecs[i].eret;    bus.epc = vecs[i].epc;
         cyc();
         idle_inputs();
         #1;
         check($sformatf("vec%0d_entry", i), 80'({bus.exc_enter, bus.exc_code, bus.cp0_din}),
               80'({vecs[i].exp_enter, vecs[i].exp_code, vecs[i].exp_din}));
         if (vecs[i].redir_cyc == 2) begin
            cyc();
            #1;
         end
         check($sformatf("vec%0d_redirect", i), 80'({bus.pc_redirect, bus.redirect_pc, bus.in_handler}),
               80'({1'b1, vecs[i].exp_rpc, vecs[i].exp_ih}));
         repeat (2) cyc();
      end

      // interrupt entry through the synchroniser
      bus.irq_in = 5'b00100; bus.sr_im = 8'h11; bus.sr_ie = 1'b1;
      bus.inst_boundary = 1'b1; bus.pc_boundary = 32'h0000_3010;
      lat = 0; got = 1'b0;
      while (!got && lat < 10) begin
         cyc();
         lat++;
         #1;
         if (bus.exc_enter) got = 1'b1;
      end
      check("irq_latency", 80'(lat), 80'(3));
      check("irq_entry", 80'({bus.exc_code, bus.hw_int, bus.cp0_din}), 80'({5'd0, 5'b00100, 32'h0000_3010}));
      bus.irq_in = '0; bus.sr_ie = 1'b0;
      cyc(); #1;
      check("irq_redirect", 80'({bus.pc_redirect, bus.redirect_pc, bus.in_handler}), 80'({1'b1, HVEC, 1'b1}));
      repeat (4) cyc();

      // masked interrupt cases: IM bit clear, IE clear, EXL set
      for (int m = 0; m < 3; m++) begin
         bus.irq_in = 5'b00100; bus.inst_boundary = 1'b1; bus.pc_boundary = 32'h0000_3010;
         bus.sr_im = (m == 0) ? 8'h01 : ((m == 2) ? 8'h13 : 8'h11);
         bus.sr_ie = (m == 1) ? 1'b0 : 1'b1;
         cnt = 0;
         repeat (20) begin
            cyc(); #1;
            if (bus.exc_enter) cnt++;
         end
         check($sformatf("masked%0d_no_entry", m), 80'(cnt), 80'(0));
         idle_inputs();
         repeat (4) cyc();
      end

      // exc_req beats take_irq; cp0_we holds ENTER for three cycles
      bus.irq_in = 5'b00100; bus.sr_im = 8'h11; bus.sr_ie = 1'b0;
      bus.inst_boundary = 1'b1; bus.pc_boundary = 32'h0000_3020;
      repeat (4) cyc();
      bus.sr_ie = 1'b1; bus.exc_req = 1'b1; bus.exc_code_in = 5'd10; bus.exc_pc = 32'h0000_3100;
      cyc();
      bus.exc_req = 1'b0; bus.sr_ie = 1'b0; bus.cp0_we = 1'b1;
      held = 0;
      repeat (3) begin
         #1;
         if (!bus.exc_enter && bus.stall) held++;
         cyc();
      end
      bus.cp0_we = 1'b0;
      #1;
      check("cp0_we_hold_cycles", 80'(held), 80'(3));
      check("prio_entry", 80'({bus.exc_enter, bus.exc_code, bus.hw_int, bus.cp0_din}),
            80'({1'b1, 5'd10, 5'b00100, 32'h0000_3100}));
      bus.irq_in = '0;
      cyc(); #1;
      check("prio_redirect", 80'({bus.pc_redirect, bus.redirect_pc}), 80'({1'b1, HVEC}));
      idle_inputs();
      repeat (4) cyc();

      // reset while in ENTER abandons the entry
      bus.exc_req = 1'b1; bus.exc_code_in = 5'd7; bus.exc_pc = 32'h0000_3200;
      cyc();
      bus.exc_req = 1'b0; reset = 1'b1;
      #1;
      check("reset_in_enter_no_pulse", 80'(bus.exc_enter), 80'(0));
      cyc();
      reset = 1'b0;
      #1;
      check("reset_in_enter_outputs", actual_out(), pack_out(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0));
      cnt = 0;
      repeat (5) begin
         cyc(); #1;
         if (bus.exc_enter) cnt++;
      end
      check("reset_in_enter_no_late_pulse", 80'(cnt), 80'(0));

      // randomized traffic checked by the monitor each cycle
      for (int n = 0; n < 3000; n++) begin
         cyc();
         reset = ($urandom_range(0, 299) == 0);
         bus.exc_req = ($urandom_range(0, 7) == 0);
         bus.exc_code_in = 5'($urandom_range(1, 31));
         bus.exc_pc = $urandom;
         bus.eret = ($urandom_range(0, 9) == 0);
         bus.epc = $urandom;
         bus.cp0_we = ($urandom_range(0, 3) == 0);
         bus.inst_boundary = ($urandom_range(0, 1) == 1);
         bus.pc_boundary = $urandom;
         if ($urandom_range(0, 15) == 0) bus.irq_in = 5'($urandom);
         if ($urandom_range(0, 31) == 0) bus.sr_im = 8'($urandom);
         bus.sr_ie = ($urandom_range(0, 3) != 0);
      end
      cyc();
      reset = 1'b0;
      idle_inputs();
      repeat (6) cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
